// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: NREQ requesters, each with a one-entry
// holding buffer, share the single WE3/A3/WD3 write port round-robin.
// Writes to R15 are dropped (R15 belongs to the PC path) and flagged on err_r15.
// pending[] exposes every buffered or in-flight destination for decode stalls.
module regfile_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     WE3,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic [2**ADDR_W-1:0]     pending,
    output logic                     err_r15
);

    localparam int PTR_W = $clog2(NREQ);
    localparam logic [ADDR_W-1:0] PC_REG = ADDR_W'(15);

    logic [NREQ-1:0]   full_p0;
    logic [ADDR_W-1:0] buf_addr_p0 [NREQ];
    logic [DATA_W-1:0] buf_data_p0 [NREQ];
    logic [PTR_W-1:0]  ptr;

    logic [NREQ-1:0]   grant;
    logic              grant_any;
    logic [PTR_W-1:0]  grant_idx;
    logic [NREQ-1:0]   accept;
    logic [NREQ-1:0]   accept_pc;

    // Round-robin pick: first full buffer at or after ptr, wrapping at NREQ-1
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!grant_any && full_p0[idx]) begin
                grant_any  = 1'b1;
                grant_idx  = idx[PTR_W-1:0];
                grant[idx] = 1'b1;
            end
        end
    end

    // A buffer can take a new write when empty or when it is draining this cycle
    always_comb begin
        req_ready = '0;
        accept    = '0;
        accept_pc = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = !full_p0[i] || grant[i];
            accept[i]    = req_valid[i] && req_ready[i];
            accept_pc[i] = accept[i] && (req_addr[i*ADDR_W +: ADDR_W] == PC_REG);
        end
    end

    // Control state: buffer occupancy, rr pointer, write port and R15 error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_p0 <= '0;
            ptr     <= '0;
            WE3     <= 1'b0;
            A3      <= '0;
            WD3     <= '0;
            err_r15 <= 1'b0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i] && !accept_pc[i]) full_p0[i] <= 1'b1;
                else if (grant[i])              full_p0[i] <= 1'b0;
            end
            WE3 <= grant_any;
            if (grant_any) begin
                A3  <= buf_addr_p0[grant_idx];
                WD3 <= buf_data_p0[grant_idx];
                if (int'(grant_idx) == NREQ - 1) ptr <= '0;
                else                             ptr <= grant_idx + 1'b1;
            end
            err_r15 <= |accept_pc;
        end
    end

    // Buffer payload capture; contents are only meaningful while full_p0 is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i] && !accept_pc[i]) begin
                buf_addr_p0[i] <= req_addr[i*ADDR_W +: ADDR_W];
                buf_data_p0[i] <= req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Hazard mask: every buffered destination plus the write currently on the port
    always_comb begin
        pending = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (full_p0[i]) pending[buf_addr_p0[i]] = 1'b1;
        end
        if (WE3) pending[A3] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int NREQ   = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   WE3;
    logic [ADDR_W-1:0]      A3;
    logic [DATA_W-1:0]      WD3;
    logic [15:0]            pending;
    logic                   err_r15;

    int n_checks = 0;
    int n_pass   = 0;

    // behavioural model state
    bit        m_full [NREQ];
    bit [3:0]  m_addr [NREQ];
    bit [31:0] m_data [NREQ];
    int        m_ptr;
    bit        m_we;
    bit [3:0]  m_a3;
    bit [31:0] m_wd3;
    bit        m_err;

    regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .WE3(WE3), .A3(A3),
        .WD3(WD3), .pending(pending), .err_r15(err_r15)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) m_full[i] = 0;
        m_ptr = 0; m_we = 0; m_a3 = 0; m_wd3 = 0; m_err = 0;
    endtask

    // which requester the rotation serves next (-1 when all buffers are empty)
    function automatic int model_pick();
        for (int k = 0; k < NREQ; k++)
            if (m_full[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic compare_all();
        logic [2:0]  exp_rdy;
        logic [15:0] exp_pend;
        int g;
        g = model_pick();
        for (int i = 0; i < NREQ; i++) exp_rdy[i] = !m_full[i] || (g == i);
        exp_pend = '0;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < NREQ; i++)
                if (m_full[i] && m_addr[i] == r[3:0]) exp_pend[r] = 1'b1;
            if (m_we && m_a3 == r[3:0]) exp_pend[r] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("WE3", 64'(WE3), 64'(m_we));
        if (m_we) begin
            chk("A3", 64'(A3), 64'(m_a3));
            chk("WD3", 64'(WD3), 64'(m_wd3));
        end
        chk("err_r15", 64'(err_r15), 64'(m_err));
        chk("pending", 64'(pending), 64'(exp_pend));
    endtask

    // apply one cycle of requests, advance the model, compare at next negedge
    task automatic cycle(input logic [2:0] v, input logic [11:0] a, input logic [95:0] d);
        bit rdy [NREQ];
        int g;
        req_valid = v; req_addr = a; req_data = d;
        g = model_pick();
        for (int i = 0; i < NREQ; i++) rdy[i] = !m_full[i] || (g == i);
        if (g >= 0) begin
            m_we = 1; m_a3 = m_addr[g]; m_wd3 = m_data[g];
            m_full[g] = 0; m_ptr = (g + 1) % NREQ;
        end else begin
            m_we = 0;
        end
        m_err = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (v[i] && rdy[i]) begin
                if (a[i*4 +: 4] == 4'd15) m_err = 1;
                else begin
                    m_full[i] = 1; m_addr[i] = a[i*4 +: 4]; m_data[i] = d[i*32 +: 32];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        cycle(3'b000, 12'h0, 96'h0);
    endtask

    initial begin
        logic [11:0] a;
        logic [95:0] d;
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        compare_all();
        chk("reset_ready", 64'(req_ready), 64'h7);
        rst = 1'b0;

        // single write
        cycle(3'b001, {4'd0, 4'd0, 4'd3}, {32'h0, 32'h0, 32'hDEADBEEF});
        chk("single_we_early", 64'(WE3), 64'h0);
        chk("single_pend_buf", 64'(pending[3]), 64'h1);
        idle();
        chk("single_we", 64'(WE3), 64'h1);
        chk("single_a3", 64'(A3), 64'h3);
        chk("single_wd3", 64'(WD3), 64'hDEADBEEF);
        chk("single_pend_we", 64'(pending[3]), 64'h1);
        idle();
        chk("single_pend_clr", 64'(pending), 64'h0);

        // back-to-back from req1
        for (int k = 0; k < 3; k++) begin
            cycle(3'b010, 12'(4'(5 + k)) << 4, 96'(32'(k + 100)) << 32);
            chk("b2b_ready1", 64'(req_ready[1]), 64'h1);
            if (k > 0) chk("b2b_a3", 64'(A3), 64'(5 + k - 1));
        end
        idle();
        chk("b2b_a3_last", 64'(A3), 64'h7);
        chk("b2b_we_last", 64'(WE3), 64'h1);
        idle();

        // R15 reject
        cycle(3'b100, {4'd15, 4'd0, 4'd0}, {32'h1, 32'h0, 32'h0});
        chk("r15_err", 64'(err_r15), 64'h1);
        chk("r15_pend", 64'(pending[15]), 64'h0);
        idle();
        chk("r15_err_clr", 64'(err_r15), 64'h0);
        chk("r15_we", 64'(WE3), 64'h0);

        // bring ptr back to 0 via one req2 write, then same-address pair
        cycle(3'b100, {4'd9, 4'd0, 4'd0}, {32'h9, 32'h0, 32'h0});
        idle(); idle();
        cycle(3'b011, {4'd0, 4'd8, 4'd8}, {32'h0, 32'hB, 32'hA});
        idle();
        chk("same_wd3_a", 64'(WD3), 64'hA);
        chk("same_pend_a", 64'(pending[8]), 64'h1);
        idle();
        chk("same_wd3_b", 64'(WD3), 64'hB);
        chk("same_pend_b", 64'(pending[8]), 64'h1);
        idle();
        chk("same_pend_clr", 64'(pending[8]), 64'h0);

        // contention: all three requesters every cycle
        for (int k = 0; k < 12; k++) begin
            cycle(3'b111, {4'd4, 4'd2, 4'd1}, {$urandom, $urandom, $urandom});
            if (k > 0) chk("cont_we", 64'(WE3), 64'h1);
        end
        for (int k = 0; k < 4; k++) idle();

        // randomized traffic with a mid-traffic reset
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                cycle(3'b111, {4'd1, 4'd2, 4'd3}, {$urandom, $urandom, $urandom});
                cycle(3'b111, {4'd4, 4'd5, 4'd6}, {$urandom, $urandom, $urandom});
                req_valid = '0;
                #2 rst = 1'b1;
                #1;
                chk("rst_we", 64'(WE3), 64'h0);
                chk("rst_pend", 64'(pending), 64'h0);
                chk("rst_ready", 64'(req_ready), 64'h7);
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                idle();
                chk("rst_no_issue", 64'(WE3), 64'h0);
            end
            for (int i = 0; i < NREQ; i++) begin
                a[i*4 +: 4]  = 4'($urandom_range(0, 15));
                d[i*32 +: 32] = $urandom;
            end
            cycle(3'($urandom_range(0, 7)), a, d);
        end
        for (int k = 0; k < 4; k++) idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
